rtr_op_sw_sched: RTL and testbench

- Per-output-port switch scheduler. Shares one output port between num_ports input-port requesters, one flit per cycle.
- Uses wormhole locking: after a head flit is granted, only that input port may use the output until its tail flit is granted.
- Gates each grant on the downstream credit state (full/almost_full per output VC) from the output port controller.
- Drives that controller's flit_valid/head/tail/sel_ovc inputs through one register stage.

---
 rtl/rtr_sched_pkg.sv | 14 +
 rtl/rtr_sched_rr_arb.sv | 22 ++
 rtl/rtr_op_sw_sched.sv | 128 ++++++++++++
 tb/tb_rtr_op_sw_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtr_sched_pkg.sv
// Shared types and constants for the per-output-port switch scheduler.
package rtr_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_e;

  localparam int ERR_BODY_UNLOCKED = 0;
  localparam int ERR_HEAD_LOCKED   = 1;
  localparam int ERR_SEL_ONEHOT    = 2;
  localparam int num_err           = 3;

endpackage

// File: rtl/rtr_sched_rr_arb.sv
// Combinational round-robin arbiter: grants the first eligible requester at
// or after the one-hot priority position, wrapping around.
module rtr_sched_rr_arb #(
  parameter int n = 5
) (
  input  logic [n-1:0] elig,
  input  logic [n-1:0] prio,
  output logic [n-1:0] gnt
);

  logic [2*n-1:0] dbl;
  logic [2*n-1:0] dgnt;

  // Doubling the request vector lets a single subtract find the first set
  // bit at or above prio, including the wrapped-around copy.
  always_comb begin
    dbl  = {elig, elig};
    dgnt = dbl & ~(dbl - {{n{1'b0}}, prio});
    gnt  = dgnt[n-1:0] | dgnt[2*n-1:n];
  end

endmodule

// File: rtl/rtr_op_sw_sched.sv
// Per-output-port switch scheduler: wormhole lock, credit-gated round-robin
// grant and a one-stage flit register toward the output port controller.
module rtr_op_sw_sched
  import rtr_sched_pkg::*;
#(
  parameter int num_ports            = 5,
  parameter int num_vcs              = 4,
  parameter bit error_capture_sticky = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_ports-1:0]         req_ip,
  input  logic [num_ports-1:0]         req_head_ip,
  input  logic [num_ports-1:0]         req_tail_ip,
  input  logic [num_ports*num_vcs-1:0] req_sel_ip_ovc,
  input  logic [num_vcs-1:0]           full_ovc,
  input  logic [num_vcs-1:0]           almost_full_ovc,
  output logic [num_ports-1:0]         gnt_ip,
  output logic                         flit_valid_out,
  output logic                         flit_head_out,
  output logic                         flit_tail_out,
  output logic [num_vcs-1:0]           flit_sel_out_ovc,
  output logic                         locked_out,
  output logic                         error
);

  logic [num_ports-1:0][num_vcs-1:0] port_sel;
  logic [num_vcs-1:0]                cred_ok;
  logic [num_ports-1:0]              elig, gnt, is_owner, e_body, e_head, e_sel;

  lock_e                lock_q, lock_d;
  logic [num_ports-1:0] lock_ip_q, lock_ip_d;
  logic [num_ports-1:0] prio_q, prio_d;
  logic                 vld_q, vld_d, head_q, head_d, tail_q, tail_d;
  logic [num_vcs-1:0]   sel_q, sel_d;
  logic [num_err-1:0]   err_q, err_d, err_now;

  assign port_sel = req_sel_ip_ovc;

  // A VC on its last credit cannot take a second flit while the pipe
  // register already holds one headed to it.
  assign cred_ok = ~full_ovc & ~(almost_full_ovc & {num_vcs{vld_q}} & sel_q);

  always_comb begin
    is_owner = '0;
    e_body   = '0;
    e_head   = '0;
    e_sel    = '0;
    elig     = '0;
    for (int p = 0; p < num_ports; p++) begin
      is_owner[p] = (lock_q == LOCKED) && lock_ip_q[p];
      e_body[p]   = req_ip[p] & ~req_head_ip[p] & ~is_owner[p];
      e_head[p]   = req_ip[p] & req_head_ip[p] & is_owner[p];
      e_sel[p]    = req_ip[p] & ~$onehot(port_sel[p]);
      elig[p]     = req_ip[p] & (|(port_sel[p] & cred_ok))
                  & ~e_body[p] & ~e_head[p] & ~e_sel[p]
                  & ((lock_q == IDLE) ? req_head_ip[p] : is_owner[p]);
    end
  end

  rtr_sched_rr_arb #(.n(num_ports)) u_arb (
    .elig (elig),
    .prio (prio_q),
    .gnt  (gnt)
  );

  always_comb begin
    vld_d  = |gnt;
    head_d = |(gnt & req_head_ip);
    tail_d = |(gnt & req_tail_ip);
    sel_d  = '0;
    for (int p = 0; p < num_ports; p++)
      if (gnt[p]) sel_d = sel_d | port_sel[p];

    lock_d    = lock_q;
    lock_ip_d = lock_ip_q;
    prio_d    = prio_q;
    if (vld_d) begin
      if (lock_q == IDLE && head_d && !tail_d) begin
        lock_d    = LOCKED;
        lock_ip_d = gnt;
      end else if (lock_q == LOCKED && tail_d) begin
        lock_d    = IDLE;
        lock_ip_d = '0;
      end
      // Pointer only advances on packet completion, so a packet's body
      // flits never cost another port its turn.
      if (tail_d) prio_d = {gnt[num_ports-2:0], gnt[num_ports-1]};
    end

    err_now                    = '0;
    err_now[ERR_BODY_UNLOCKED] = |e_body;
    err_now[ERR_HEAD_LOCKED]   = |e_head;
    err_now[ERR_SEL_ONEHOT]    = |e_sel;
    err_d = error_capture_sticky ? (err_q | err_now) : err_now;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q    <= IDLE;
      lock_ip_q <= '0;
      prio_q    <= num_ports'(1);
      vld_q     <= 1'b0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      sel_q     <= '0;
      err_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ip_q <= lock_ip_d;
      prio_q    <= prio_d;
      vld_q     <= vld_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
    end
  end

  assign gnt_ip           = gnt;
  assign flit_valid_out   = vld_q;
  assign flit_head_out    = head_q;
  assign flit_tail_out    = tail_q;
  assign flit_sel_out_ovc = sel_q;
  assign locked_out       = (lock_q == LOCKED);
  assign error            = |err_q;

endmodule

// File: tb/tb_rtr_op_sw_sched.sv
// Directed and randomized checks of rtr_op_sw_sched against a packet-level
// reference model (owner port number, pointer index, last granted flit).
module tb_rtr_op_sw_sched;
  localparam int NP     = 5;
  localparam int NV     = 4;
  localparam bit STICKY = 1'b1;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    req, hd, tl;
  logic [NP*NV-1:0] sel;
  logic [NV-1:0]    full, af;
  logic [NP-1:0]    gnt_ip;
  logic             flit_valid_out, flit_head_out, flit_tail_out, locked_out, error;
  logic [NV-1:0]    flit_sel_out_ovc;

  rtr_op_sw_sched #(.num_ports(NP), .num_vcs(NV), .error_capture_sticky(STICKY)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_ip           (req),
    .req_head_ip      (hd),
    .req_tail_ip      (tl),
    .req_sel_ip_ovc   (sel),
    .full_ovc         (full),
    .almost_full_ovc  (af),
    .gnt_ip           (gnt_ip),
    .flit_valid_out   (flit_valid_out),
    .flit_head_out    (flit_head_out),
    .flit_tail_out    (flit_tail_out),
    .flit_sel_out_ovc (flit_sel_out_ovc),
    .locked_out       (locked_out),
    .error            (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int m_own, m_ptr;
  bit m_pv, m_ph, m_pt;
  bit [NV-1:0] m_psel;
  bit [2:0] m_err;
  logic [NP-1:0] obs_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NV-1:0] psel(input int p);
    return sel[p*NV +: NV];
  endfunction

  function automatic int vc_of(input logic [NV-1:0] s);
    for (int v = 0; v < NV; v++) if (s[v]) return v;
    return 0;
  endfunction

  function automatic bit port_ok(input int p);
    logic [NV-1:0] s;
    int v;
    s = psel(p);
    if (!req[p] || $countones(s) != 1) return 0;
    v = vc_of(s);
    if (full[v] || (af[v] && m_pv && m_psel[v])) return 0;
    if (m_own < 0) return hd[p];
    return (p == m_own) && !hd[p];
  endfunction

  function automatic logic [NP-1:0] model_gnt();
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_ptr + k) % NP;
      if (port_ok(p)) return NP'(1) << p;
    end
    return '0;
  endfunction

  task automatic model_clock(input logic [NP-1:0] g);
    bit [2:0] e;
    int gp;
    e = '0;
    for (int p = 0; p < NP; p++) if (req[p]) begin
      if (!hd[p] && p != m_own) e[0] = 1'b1;
      if (hd[p] && p == m_own) e[1] = 1'b1;
      if ($countones(psel(p)) != 1) e[2] = 1'b1;
    end
    m_err = STICKY ? (m_err | e) : e;
    if (g != '0) begin
      gp = 0;
      for (int p = 0; p < NP; p++) if (g[p]) gp = p;
      m_pv = 1; m_ph = hd[gp]; m_pt = tl[gp]; m_psel = psel(gp);
      if (m_own < 0 && hd[gp] && !tl[gp]) m_own = gp;
      else if (m_own >= 0 && tl[gp]) m_own = -1;
      if (tl[gp]) m_ptr = (gp + 1) % NP;
    end else begin
      m_pv = 0; m_ph = 0; m_pt = 0; m_psel = '0;
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_pv = 0; m_ph = 0; m_pt = 0; m_psel = '0; m_err = '0;
  endtask

  task automatic check_outs();
    chk("valid", 32'(flit_valid_out), 32'(m_pv));
    chk("head", 32'(flit_head_out), 32'(m_ph));
    chk("tail", 32'(flit_tail_out), 32'(m_pt));
    chk("sel", 32'(flit_sel_out_ovc), 32'(m_psel));
    chk("locked", 32'(locked_out), 32'(m_own >= 0));
    chk("error", 32'(error), 32'(|m_err));
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    logic [NP-1:0] mg;
    #1;
    mg = model_gnt();
    obs_gnt = gnt_ip;
    chk("gnt", 32'(gnt_ip), 32'(mg));
    @(posedge clk);
    model_clock(mg);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic clr();
    req = '0; hd = '0; tl = '0; sel = '0; full = '0; af = '0;
  endtask

  task automatic set_req(input int p, input bit h, input bit t, input int vc);
    req[p] = 1'b1; hd[p] = h; tl[p] = t; sel[p*NV +: NV] = NV'(1) << vc;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("rst_gnt", 32'(gnt_ip), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int exp_order[6];
    reset = 1'b1;
    clr();
    model_reset();
    do_reset();

    // Single-flit packet from port 2, then pointer check via ports 2 and 4.
    set_req(2, 1, 1, 2);
    cycle();
    chk("tp1_gnt", 32'(obs_gnt), 32'b00100);
    chk("tp1_sel", 32'(flit_sel_out_ovc), 32'b0100);
    chk("tp1_lock", 32'(locked_out), 32'h0);
    clr();
    set_req(2, 1, 1, 0); set_req(4, 1, 1, 1);
    cycle();
    chk("tp1_ptr", 32'(obs_gnt), 32'b10000);
    clr();

    // Three-flit packet from port 0 with port 4 contending.
    set_req(0, 1, 0, 3); set_req(4, 1, 1, 2);
    cycle();
    chk("tp2_g1", 32'(obs_gnt), 32'b00001);
    chk("tp2_l1", 32'(locked_out), 32'h1);
    set_req(0, 0, 0, 3);
    cycle();
    chk("tp2_g2", 32'(obs_gnt), 32'b00001);
    chk("tp2_l2", 32'(locked_out), 32'h1);
    set_req(0, 0, 1, 3);
    cycle();
    chk("tp2_g3", 32'(obs_gnt), 32'b00001);
    req[0] = 1'b0;
    cycle();
    chk("tp2_g4", 32'(obs_gnt), 32'b10000);
    clr();

    // Last-credit stall on VC0 for port 1's body flit.
    set_req(1, 1, 0, 0);
    cycle();
    set_req(1, 0, 0, 0); af[0] = 1'b1;
    cycle();
    chk("tp3_stall", 32'(obs_gnt), 32'h0);
    af[0] = 1'b0;
    cycle();
    chk("tp3_go", 32'(obs_gnt), 32'b00010);
    set_req(1, 0, 1, 0);
    cycle();
    clr();

    // Fairness among ports 0, 1, 3 from a reset pointer.
    do_reset();
    exp_order = '{0, 1, 3, 0, 1, 3};
    set_req(0, 1, 1, 0); set_req(1, 1, 1, 1); set_req(3, 1, 1, 2);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("tp4_rr", 32'(obs_gnt), 32'(NP'(1) << exp_order[i]));
    end
    clr();

    // Body flit with no lock held: not granted, sticky error.
    set_req(2, 0, 0, 1);
    cycle();
    chk("tp5_gnt", 32'(obs_gnt), 32'h0);
    chk("tp5_err", 32'(error), 32'h1);
    clr();
    cycle();
    chk("tp5_hold", 32'(error), 32'h1);

    // Reset mid-packet while locked to port 3.
    do_reset();
    set_req(3, 1, 0, 2);
    cycle();
    set_req(3, 0, 0, 2);
    cycle();
    chk("tp6_pre", 32'(locked_out), 32'h1);
    reset = 1'b0;
    #1;
    chk("tp6_v", 32'(flit_valid_out), 32'h0);
    chk("tp6_h", 32'(flit_head_out), 32'h0);
    chk("tp6_s", 32'(flit_sel_out_ovc), 32'h0);
    chk("tp6_l", 32'(locked_out), 32'h0);
    chk("tp6_g", 32'(gnt_ip), 32'h0);
    model_reset();
    clr();
    @(negedge clk);
    reset = 1'b1;
    set_req(1, 1, 1, 0);
    cycle();
    chk("tp6_post", 32'(obs_gnt), 32'b00010);
    clr();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end
      for (int p = 0; p < NP; p++) begin
        req[p] = $urandom_range(1);
        hd[p]  = ($urandom_range(3) == 0);
        tl[p]  = ($urandom_range(2) == 0);
        if ($urandom_range(15) == 0) sel[p*NV +: NV] = NV'($urandom);
        else sel[p*NV +: NV] = NV'(1) << $urandom_range(NV-1);
      end
      for (int v = 0; v < NV; v++) begin
        full[v] = ($urandom_range(7) == 0);
        af[v]   = ($urandom_range(2) == 0);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
